// File: rtl/intdiv_recon_pkg.sv
// Shared definitions for the intdiv_recon dividend reconstructor: FSM encoding and counter width.
package intdiv_recon_pkg;

    // Bit counter width; supports operand widths up to 255 bits.
    localparam int unsigned CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/intdiv_recon_step.sv
// One shift-add step of the signed multiply: conditionally add (or subtract, for the sign bit) y << k.
module intdiv_recon_step
    import intdiv_recon_pkg::*;
#(
    parameter int unsigned N = 32
) (
    input  logic [2*N-1:0]   acc,
    input  logic [N-1:0]     y,
    input  logic             zbit,
    input  logic [CNT_W-1:0] k,
    output logic [2*N-1:0]   sum_c
);

    localparam int unsigned AW = 2 * N;

    logic [AW-1:0] ys;
    logic [AW-1:0] sh;

    assign ys = {{N{y[N-1]}}, y};
    assign sh = ys << k;

    // The multiplier's top bit carries negative weight in two's complement.
    always_comb begin
        sum_c = acc;
        if (zbit) begin
            if (k == CNT_W'(N - 1)) sum_c = acc - sh;
            else                    sum_c = acc + sh;
        end
    end

endmodule

// File: rtl/intdiv_recon.sv
// Reconstructs a dividend x = z*y + r with a bit-serial signed multiplier, one quotient bit per cycle.
// Optional overflow flag enabled by defining INTDIV_RECON_OVF_EN.
module intdiv_recon #(
    parameter int unsigned N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] z,
    input  logic [N-1:0] y,
    input  logic [N-1:0] r,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] x,
    output logic         ovf
);

    import intdiv_recon_pkg::*;

    localparam int unsigned AW = 2 * N;

    state_t            state;
    state_t            state_nxt;
    logic [N-1:0]      zl;
    logic [N-1:0]      yl;
    logic [AW-1:0]     acc;
    logic [AW-1:0]     acc_nxt;
    logic [CNT_W-1:0]  cnt;
    logic              last;
    logic              accept;

    assign last   = (cnt == CNT_W'(N - 1));
    assign accept = start && (state != RUN);

    intdiv_recon_step #(.N(N)) u_step (
        .acc   (acc),
        .y     (yl),
        .zbit  (zl[0]),
        .k     (cnt),
        .sum_c (acc_nxt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last)  state_nxt = DONE;
            DONE:    state_nxt = start ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        busy = (state == RUN);
        done = (state == DONE);
    end

    // Operand latch, accumulator and result capture; z is shifted so bit k is always at zl[0].
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zl  <= '0;
            yl  <= '0;
            acc <= '0;
            cnt <= '0;
            x   <= '0;
        end else if (accept) begin
            zl  <= z;
            yl  <= y;
            acc <= {{N{r[N-1]}}, r};
            cnt <= '0;
        end else if (state == RUN) begin
            zl  <= zl >> 1;
            acc <= acc_nxt;
            cnt <= cnt + CNT_W'(1);
            if (last) x <= acc_nxt[N-1:0];
        end
    end

`ifdef INTDIV_RECON_OVF_EN
    logic [N:0] top_bits;
    logic       ovf_q;

    // Result fits in N signed bits only if the sign bit and everything above it agree.
    assign top_bits = acc_nxt[AW-1:N-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                       ovf_q <= 1'b0;
        else if ((state == RUN) && last)  ovf_q <= !((&top_bits) || !(|top_bits));
    end

    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_intdiv_recon.sv
// Self-checking bench for intdiv_recon (N = 8) against an integer-arithmetic reference model.
module tb_intdiv_recon;

    localparam int unsigned N = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [N-1:0] z;
    logic [N-1:0] y;
    logic [N-1:0] r;
    logic         busy;
    logic         done;
    logic [N-1:0] x;
    logic         ovf;

    int tests;
    int fails;

    intdiv_recon #(.N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .z     (z),
        .y     (y),
        .r     (r),
        .busy  (busy),
        .done  (done),
        .x     (x),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: exact signed product-plus-remainder in 64-bit integers.
    task automatic model(input logic [N-1:0] zi, input logic [N-1:0] yi, input logic [N-1:0] ri,
                         output logic [N-1:0] xe, output logic oe);
        longint ex;
        ex = longint'($signed(zi)) * longint'($signed(yi)) + longint'($signed(ri));
        xe = ex[N-1:0];
`ifdef INTDIV_RECON_OVF_EN
        oe = (ex > 127) || (ex < -128);
`else
        oe = 1'b0;
`endif
    endtask

    task automatic run_op(input logic [N-1:0] zi, input logic [N-1:0] yi, input logic [N-1:0] ri,
                          input string tag);
        logic [N-1:0] xe;
        logic         oe;
        model(zi, yi, ri, xe, oe);
        @(negedge clk);
        start = 1'b1; z = zi; y = yi; r = ri;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < int'(N); i++) begin
            check({tag, " busy"}, 16'(busy), 16'(1));
            check({tag, " done_early"}, 16'(done), 16'(0));
            @(negedge clk);
        end
        check({tag, " done"}, 16'(done), 16'(1));
        check({tag, " busy_off"}, 16'(busy), 16'(0));
        check({tag, " x"}, 16'(x), 16'(xe));
        check({tag, " ovf"}, 16'(ovf), 16'(oe));
        @(negedge clk);
        check({tag, " done_pulse"}, 16'(done), 16'(0));
        check({tag, " x_hold"}, 16'(x), 16'(xe));
    endtask

    initial begin
        logic [N-1:0] xe;
        logic [N-1:0] xe2;
        logic         oe;
        logic         oe2;
        int           dcnt;

        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        start = 1'b0;
        z = '0; y = '0; r = '0;
        repeat (2) @(negedge clk);
        check("rst busy", 16'(busy), 16'(0));
        check("rst done", 16'(done), 16'(0));
        check("rst x", 16'(x), 16'(0));
        check("rst ovf", 16'(ovf), 16'(0));
        rst_n = 1'b1;

        run_op(8'hFD, 8'h07, 8'hFE, "m3x7m2");
        check("m3x7m2 abs", 16'(x), 16'(8'hE9));
        run_op(8'h0C, 8'hFB, 8'h03, "12xm5p3");
        check("12xm5p3 abs", 16'(x), 16'(8'hC7));
        run_op(8'h80, 8'h01, 8'h00, "zmin");
        check("zmin abs", 16'(x), 16'(8'h80));
        run_op(8'h64, 8'h64, 8'h00, "100x100");
        check("100x100 abs", 16'(x), 16'(8'h10));
        run_op(8'h00, 8'h5A, 8'hC3, "z0");
        run_op(8'h37, 8'h00, 8'h81, "y0");
        run_op(8'h80, 8'h80, 8'h7F, "zmin_ymin");

        for (int n = 0; n < 20; n++)
            run_op(N'($urandom), N'($urandom), N'($urandom), "rand");

        // A start during RUN must not disturb the operation in flight.
        model(8'h15, 8'hF3, 8'h09, xe, oe);
        @(negedge clk);
        start = 1'b1; z = 8'h15; y = 8'hF3; r = 8'h09;
        dcnt = 0;
        for (int i = 0; i < int'(N); i++) begin
            @(negedge clk);
            start = (i == 2);
            if (i == 2) begin z = 8'h7E; y = 8'h22; r = 8'h40; end
            dcnt += int'(done);
        end
        start = 1'b0;
        @(negedge clk);
        check("ign done", 16'(done), 16'(1));
        check("ign x", 16'(x), 16'(xe));
        check("ign ovf", 16'(ovf), 16'(oe));
        for (int i = 0; i < int'(N) + 2; i++) begin
            dcnt += int'(done);
            @(negedge clk);
        end
        check("ign one_pulse", 16'(dcnt), 16'(1));

        // Reset mid-run: outputs clear at once and the aborted op never completes.
        @(negedge clk);
        start = 1'b1; z = 8'h21; y = 8'h05; r = 8'h02;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        check("arst busy", 16'(busy), 16'(0));
        check("arst done", 16'(done), 16'(0));
        check("arst x", 16'(x), 16'(0));
        check("arst ovf", 16'(ovf), 16'(0));
        @(negedge clk);
        rst_n = 1'b1;
        dcnt = 0;
        for (int i = 0; i < int'(N) + 3; i++) begin
            @(negedge clk);
            dcnt += int'(done) + int'(busy);
        end
        check("arst no_done", 16'(dcnt), 16'(0));
        run_op(8'h21, 8'h05, 8'h02, "post_rst");

        // Back-to-back: start held through DONE launches the next op immediately.
        model(8'hF6, 8'h0B, 8'h05, xe, oe);
        model(8'h09, 8'h9C, 8'hF0, xe2, oe2);
        @(negedge clk);
        start = 1'b1; z = 8'hF6; y = 8'h0B; r = 8'h05;
        for (int i = 0; i < int'(N); i++) begin
            @(negedge clk);
            check("b2b busy1", 16'(busy), 16'(1));
        end
        @(negedge clk);
        check("b2b done1", 16'(done), 16'(1));
        check("b2b x1", 16'(x), 16'(xe));
        check("b2b ovf1", 16'(ovf), 16'(oe));
        z = 8'h09; y = 8'h9C; r = 8'hF0;
        @(negedge clk);
        start = 1'b0;
        check("b2b restart", 16'(busy), 16'(1));
        for (int i = 1; i < int'(N); i++) begin
            @(negedge clk);
            check("b2b busy2", 16'(busy), 16'(1));
            check("b2b done_gap", 16'(done), 16'(0));
        end
        @(negedge clk);
        check("b2b done2", 16'(done), 16'(1));
        check("b2b x2", 16'(x), 16'(xe2));
        check("b2b ovf2", 16'(ovf), 16'(oe2));
        @(negedge clk);
        check("b2b idle", 16'(done), 16'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
